btb_assoc: RTL and testbench

- Parametrised, set-associative branch target buffer built from synthesizable flops. It replaces the single-entry-per-index DPI-backed BTB model.
- Adds partial tags, per-entry 2-bit direction counters, victim selection and a multi-cycle flush walker.
- Sits in the IF stage. It takes a lookup from the PC generator and returns a prediction one cycle later. The EX/branch-resolve stage trains it through the update port.

---
 rtl/btb_assoc.sv | 201 ++++++++++++++++++++
 tb/tb_btb_assoc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_assoc.sv
// -----------------------------------------------------------------------------
// btb_assoc -- set-associative branch target buffer for the IF stage.
//
// A lookup (lk_valid & lk_ready) is captured at the clock edge and answered in
// the next cycle on rsp_*. The answer reflects the table contents from before
// any update accepted at the same edge. Training arrives on upd_* from branch
// resolve. A flush pulse starts a walker that clears one set per cycle.
//
// Handshake: lk_ready is high only when the buffer can take a lookup (out of
// reset, not flushing, no flush request this cycle). A lookup transfers on the
// edge where lk_valid & lk_ready are both high. rsp_valid pulses for exactly
// one cycle after each transfer. There is no response backpressure. upd_valid
// has no ready and is taken in IDLE when flush is low.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   lk_valid/lk_ready lookup request / accept
//   lk_pc             fetch PC
//   rsp_valid         response strobe, one cycle after an accepted lookup
//   rsp_hit           tag hit in a valid way
//   rsp_taken         hit with counter MSB set
//   rsp_target        stored target (0 on miss)
//   rsp_way           hitting way (0 on miss)
//   upd_valid/pc/taken/target  training request
//   flush             start full invalidation (pulse)
//   flush_busy        walker active
//   dbg_state         FSM state (0 = IDLE, 1 = FLUSH)
// -----------------------------------------------------------------------------
module btb_assoc #(
  parameter int SETS   = 64,
  parameter int WAYS   = 2,
  parameter int TAG_W  = 8,
  parameter int ADDR_W = 32,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lk_valid,
  output logic              lk_ready,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic              rsp_taken,
  output logic [ADDR_W-1:0] rsp_target,
  output logic [WAY_W-1:0]  rsp_way,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              flush,
  output logic              flush_busy,
  output logic              dbg_state
);

  typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_walk;
  logic [WAYS-1:0]    r_valid [SETS];
  logic [WAY_W-1:0]   r_vptr  [SETS];
  logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
  logic [ADDR_W-1:0]  r_tgt   [SETS][WAYS];
  logic [1:0]         r_ctr   [SETS][WAYS];

  logic               r_rsp_valid, r_rsp_hit, r_rsp_taken;
  logic [ADDR_W-1:0]  r_rsp_target;
  logic [WAY_W-1:0]   r_rsp_way;

  // Address decode; PC bits [1:0] never participate.
  logic [IDX_W-1:0]   w_lk_idx, w_upd_idx;
  logic [TAG_W-1:0]   w_lk_tag, w_upd_tag;
  assign w_lk_idx  = lk_pc[IDX_W+1:2];
  assign w_lk_tag  = lk_pc[IDX_W+2 +: TAG_W];
  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[IDX_W+2 +: TAG_W];

  logic w_idle_ok, w_lk_acc, w_upd_en;
  assign w_idle_ok = rst & (r_state == ST_IDLE) & ~flush;
  assign w_lk_acc  = lk_valid & w_idle_ok;
  assign w_upd_en  = upd_valid & w_idle_ok;

  // Parallel compare of every way; scanning downwards lets the lowest way win.
  logic              w_lk_hit, w_lk_ctr1;
  logic [WAY_W-1:0]  w_lk_way;
  logic [ADDR_W-1:0] w_lk_tgt;
  always_comb begin
    w_lk_hit  = 1'b0;
    w_lk_ctr1 = 1'b0;
    w_lk_way  = '0;
    w_lk_tgt  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_lk_idx][WAY_W'(w)] && (r_tag[w_lk_idx][WAY_W'(w)] == w_lk_tag)) begin
        w_lk_hit  = 1'b1;
        w_lk_way  = WAY_W'(w);
        w_lk_tgt  = r_tgt[w_lk_idx][WAY_W'(w)];
        w_lk_ctr1 = r_ctr[w_lk_idx][WAY_W'(w)][1];
      end
    end
  end

  // Update side: hit way, lowest invalid way, and the allocation choice.
  logic             w_upd_hit, w_upd_inv;
  logic [WAY_W-1:0] w_upd_hway, w_upd_iway, w_alloc_way, w_vptr_nxt;
  always_comb begin
    w_upd_hit  = 1'b0;
    w_upd_inv  = 1'b0;
    w_upd_hway = '0;
    w_upd_iway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_upd_idx][WAY_W'(w)] && (r_tag[w_upd_idx][WAY_W'(w)] == w_upd_tag)) begin
        w_upd_hit  = 1'b1;
        w_upd_hway = WAY_W'(w);
      end
      if (!r_valid[w_upd_idx][WAY_W'(w)]) begin
        w_upd_inv  = 1'b1;
        w_upd_iway = WAY_W'(w);
      end
    end
  end
  // With WAYS=1 the pointer is a constant 0 and folds away.
  assign w_alloc_way = w_upd_inv ? w_upd_iway : r_vptr[w_upd_idx];
  assign w_vptr_nxt  = (r_vptr[w_upd_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                 : r_vptr[w_upd_idx] + WAY_W'(1);

  // Control state: FSM, walker, valid bits, victim pointers, response regs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_walk       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_hit    <= 1'b0;
      r_rsp_taken  <= 1'b0;
      r_rsp_target <= '0;
      r_rsp_way    <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[IDX_W'(s)] <= '0;
        r_vptr[IDX_W'(s)]  <= '0;
      end
    end else begin
      r_rsp_valid  <= w_lk_acc;
      r_rsp_hit    <= w_lk_acc & w_lk_hit;
      r_rsp_taken  <= w_lk_acc & w_lk_hit & w_lk_ctr1;
      r_rsp_target <= (w_lk_acc & w_lk_hit) ? w_lk_tgt : '0;
      r_rsp_way    <= (w_lk_acc & w_lk_hit) ? w_lk_way : '0;
      case (r_state)
        ST_IDLE: begin
          if (flush) begin
            r_state <= ST_FLUSH;
            r_walk  <= '0;
          end else if (w_upd_en && !w_upd_hit && upd_taken) begin
            r_valid[w_upd_idx][w_alloc_way] <= 1'b1;
            if (!w_upd_inv) r_vptr[w_upd_idx] <= w_vptr_nxt;
          end
        end
        ST_FLUSH: begin
          r_valid[r_walk] <= '0;
          r_vptr[r_walk]  <= '0;
          if (flush) begin
            r_walk <= '0;
          end else if (r_walk == IDX_W'(SETS - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_walk <= r_walk + IDX_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Payload arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (w_upd_en) begin
      if (w_upd_hit) begin
        r_tgt[w_upd_idx][w_upd_hway] <= upd_target;
        if (upd_taken) begin
          if (r_ctr[w_upd_idx][w_upd_hway] != 2'b11)
            r_ctr[w_upd_idx][w_upd_hway] <= r_ctr[w_upd_idx][w_upd_hway] + 2'b01;
        end else begin
          if (r_ctr[w_upd_idx][w_upd_hway] != 2'b00)
            r_ctr[w_upd_idx][w_upd_hway] <= r_ctr[w_upd_idx][w_upd_hway] - 2'b01;
        end
      end else if (upd_taken) begin
        r_tag[w_upd_idx][w_alloc_way] <= w_upd_tag;
        r_tgt[w_upd_idx][w_alloc_way] <= upd_target;
        r_ctr[w_upd_idx][w_alloc_way] <= 2'b10;
      end
    end
  end

  assign lk_ready   = w_idle_ok;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_hit    = r_rsp_hit;
  assign rsp_taken  = r_rsp_taken;
  assign rsp_target = r_rsp_target;
  assign rsp_way    = r_rsp_way;
  assign flush_busy = (r_state == ST_FLUSH);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_btb_assoc.sv
module tb_btb_assoc;
  localparam int SETS = 64, WAYS = 2, TAG_W = 8, ADDR_W = 32, IDX_W = 6, WAY_W = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              lk_valid = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0, flush = 1'b0;
  logic [ADDR_W-1:0] lk_pc = '0, upd_pc = '0, upd_target = '0;
  logic              lk_ready, rsp_valid, rsp_hit, rsp_taken, flush_busy, dbg_state;
  logic [ADDR_W-1:0] rsp_target;
  logic [WAY_W-1:0]  rsp_way;

  btb_assoc #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_pc(lk_pc),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_taken(rsp_taken),
    .rsp_target(rsp_target), .rsp_way(rsp_way),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .flush(flush), .flush_busy(flush_busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  logic [31:0] m_tgt   [SETS][WAYS];
  int          m_ctr   [SETS][WAYS];
  int          m_vptr  [SETS];
  int          m_busy = 0;   // flush cycles still to run

  logic        exp_valid = 0, exp_hit = 0, exp_taken = 0;
  logic [31:0] exp_target = 0, exp_way = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % SETS);
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] pc);
    return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
  endfunction

  task automatic model_invalidate();
    for (int s = 0; s < SETS; s++) begin
      m_vptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
    end
  endtask

  task automatic model_step();
    bit acc, upd;
    int s, hw, a;
    int unsigned t;
    acc = lk_valid && (m_busy == 0) && !flush;
    upd = upd_valid && (m_busy == 0) && !flush;
    // response from contents as they stood before this edge
    exp_valid = acc; exp_hit = 0; exp_taken = 0; exp_target = 0; exp_way = 0;
    if (acc) begin
      s = idx_of(lk_pc); t = tag_of(lk_pc);
      for (int w = 0; w < WAYS; w++)
        if (!exp_hit && m_valid[s][w] && m_tag[s][w] == t) begin
          exp_hit = 1; exp_taken = (m_ctr[s][w] >= 2);
          exp_target = m_tgt[s][w]; exp_way = w;
        end
    end
    if (upd) begin
      s = idx_of(upd_pc); t = tag_of(upd_pc); hw = -1;
      for (int w = 0; w < WAYS; w++)
        if (hw < 0 && m_valid[s][w] && m_tag[s][w] == t) hw = w;
      if (hw >= 0) begin
        m_tgt[s][hw] = upd_target;
        if (upd_taken) m_ctr[s][hw] = (m_ctr[s][hw] == 3) ? 3 : m_ctr[s][hw] + 1;
        else           m_ctr[s][hw] = (m_ctr[s][hw] == 0) ? 0 : m_ctr[s][hw] - 1;
      end else if (upd_taken) begin
        a = -1;
        for (int w = 0; w < WAYS; w++) if (a < 0 && !m_valid[s][w]) a = w;
        if (a < 0) begin a = m_vptr[s]; m_vptr[s] = (m_vptr[s] + 1) % WAYS; end
        m_valid[s][a] = 1; m_tag[s][a] = t; m_tgt[s][a] = upd_target; m_ctr[s][a] = 2;
      end
    end
    // Nothing is observable inside the walk, so the model drops all entries at once.
    if (flush) begin
      model_invalidate();
      m_busy = SETS;
    end else if (m_busy > 0) begin
      m_busy--;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_invalidate();
      m_busy = 0;
      exp_valid = 0; exp_hit = 0; exp_taken = 0; exp_target = 0; exp_way = 0;
    end else begin
      model_step();
    end
  end

  // ---------------- compare process (every cycle, on the falling edge) ----------------
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("rsp_valid",  rsp_valid,  exp_valid);
      chk("rsp_hit",    rsp_hit,    exp_hit);
      chk("rsp_taken",  rsp_taken,  exp_taken);
      chk("rsp_target", rsp_target, exp_target);
      chk("rsp_way",    rsp_way,    exp_way);
      chk("flush_busy", flush_busy, (rst && m_busy > 0));
      chk("dbg_state",  dbg_state,  (rst && m_busy > 0));
      chk("lk_ready",   lk_ready,   (rst && m_busy == 0 && !flush));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    cyc();
    upd_valid = 0;
  endtask

  task automatic lookup_lit(input logic [31:0] pc, input logic h, input logic tk,
                            input logic [31:0] tgt, input string nm);
    lk_valid = 1; lk_pc = pc;
    cyc();
    lk_valid = 0;
    chk({nm, "_valid"},  rsp_valid,  1);
    chk({nm, "_hit"},    rsp_hit,    h);
    chk({nm, "_taken"},  rsp_taken,  tk);
    chk({nm, "_target"}, rsp_target, tgt);
  endtask

  task automatic pulse_flush();
    flush = 1; cyc(); flush = 0;
  endtask

  // Counts busy cycles with a bound, driving updates that must be ignored.
  task automatic count_busy(input string nm);
    int cnt;
    cnt = 0;
    while (flush_busy === 1'b1 && cnt < 200) begin
      chk({nm, "_rdy"}, lk_ready, 0);
      upd_valid = 1; upd_pc = 32'h8000_0300; upd_taken = 1; upd_target = 32'h1234_5678;
      cnt++;
      cyc();
    end
    upd_valid = 0;
    chk({nm, "_len"}, cnt, SETS);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] pcs[5];
    repeat (3) @(posedge clk);
    #2 rst = 1;
    cyc();

    // cold lookup
    lookup_lit(32'h8000_0010, 0, 0, 32'h0, "cold");
    chk("cold_way", rsp_way, 0);

    // allocate then hit, counter saturation both ways
    do_upd(32'h8000_0010, 1, 32'h8000_0100);
    lookup_lit(32'h8000_0010, 1, 1, 32'h8000_0100, "alloc");
    do_upd(32'h8000_0010, 1, 32'h8000_0100);   // 3
    do_upd(32'h8000_0010, 1, 32'h8000_0100);   // stays 3
    do_upd(32'h8000_0010, 0, 32'h8000_0100);   // 2
    lookup_lit(32'h8000_0010, 1, 1, 32'h8000_0100, "sat3");
    do_upd(32'h8000_0010, 0, 32'h8000_0100);   // 1
    do_upd(32'h8000_0010, 0, 32'h8000_0100);   // 0
    lookup_lit(32'h8000_0010, 1, 0, 32'h8000_0100, "ctr_low");
    do_upd(32'h8000_0010, 0, 32'h8000_0100);   // stays 0
    do_upd(32'h8000_0010, 1, 32'h8000_0100);   // 1
    do_upd(32'h8000_0010, 1, 32'h8000_0100);   // 2
    lookup_lit(32'h8000_0010, 1, 1, 32'h8000_0100, "sat0");

    // conflict in set 4: third tag evicts way 0
    do_upd(32'h8000_0110, 1, 32'h8000_0A00);
    do_upd(32'h8000_0210, 1, 32'h8000_0B00);
    lookup_lit(32'h8000_0010, 0, 0, 32'h0, "evicted");
    lookup_lit(32'h8000_0110, 1, 1, 32'h8000_0A00, "way1");
    chk("way1_way", rsp_way, 1);
    lookup_lit(32'h8000_0210, 1, 1, 32'h8000_0B00, "way0");
    chk("way0_way", rsp_way, 0);

    // same-cycle lookup and allocating update
    lk_valid = 1; lk_pc = 32'h8000_0020;
    upd_valid = 1; upd_pc = 32'h8000_0020; upd_taken = 1; upd_target = 32'h8000_0C00;
    cyc();
    lk_valid = 0; upd_valid = 0;
    chk("hazard_hit", rsp_hit, 0);
    lookup_lit(32'h8000_0020, 1, 1, 32'h8000_0C00, "hazard_next");

    // flush of five populated sets, updates during the walk ignored
    for (int i = 0; i < 5; i++) begin
      pcs[i] = 32'h8000_0040 + 32'(i * 4);
      do_upd(pcs[i], 1, 32'h9000_0000 + 32'(i));
    end
    lookup_lit(pcs[2], 1, 1, 32'h9000_0002, "pre_flush");
    pulse_flush();
    count_busy("flush");
    for (int i = 0; i < 5; i++) lookup_lit(pcs[i], 0, 0, 32'h0, "post_flush");
    lookup_lit(32'h8000_0300, 0, 0, 32'h0, "flush_upd_ignored");

    // re-pulse 30 cycles into the walk
    pulse_flush();
    repeat (29) cyc();
    pulse_flush();
    count_busy("reflush");

    // asynchronous reset in the middle of a walk
    do_upd(32'h8000_00F0, 1, 32'h8000_0D00);   // set 60, not reached by walk cycle 10
    pulse_flush();
    repeat (10) cyc();
    rst = 0;
    #1;
    chk("arst_busy",  flush_busy, 0);
    chk("arst_ready", lk_ready,   0);
    chk("arst_valid", rsp_valid,  0);
    chk("arst_hit",   rsp_hit,    0);
    chk("arst_tgt",   rsp_target, 0);
    repeat (2) cyc();
    rst = 1;
    cyc();
    chk("post_rst_busy",  flush_busy, 0);
    chk("post_rst_ready", lk_ready,   1);
    lookup_lit(32'h8000_00F0, 0, 0, 32'h0, "post_rst");
    lookup_lit(32'h8000_0110, 0, 0, 32'h0, "post_rst2");

    // randomized traffic over a small PC pool to force conflicts and hits
    for (int n = 0; n < 3000; n++) begin
      lk_valid   = ($urandom_range(0, 1) == 1);
      lk_pc      = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 2) | (32'($urandom_range(0, 3)) << 8)
                   | 32'($urandom_range(0, 3));
      upd_valid  = ($urandom_range(0, 1) == 1);
      upd_pc     = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 2) | (32'($urandom_range(0, 3)) << 8);
      upd_taken  = ($urandom_range(0, 2) != 0);
      upd_target = $urandom;
      flush      = ($urandom_range(0, 199) == 0);
      cyc();
    end
    lk_valid = 0; upd_valid = 0; flush = 0;
    for (int n = 0; n < 100 && flush_busy === 1'b1; n++) cyc();
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
